// File: rtl/shift_sequencer_pkg.sv
// Shared state encodings and count-width derivation for the shift sequencer.
package shift_sequencer_pkg;

  // LOAD exists as an encoding only; loading happens in the IDLE accept cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command/response handshake bundle between a requester and the shift sequencer.
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_rotate;
  logic             cmd_fill;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_rotate, cmd_fill,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_rotate, cmd_fill,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry
  );

endinterface

// File: rtl/shift_sequencer_bidir_shift_reg.sv
// Bidirectional shift register with parallel load; load wins over shift enable.
module bidir_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             load,
  input  logic             dir,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en) begin
      // dir=1 moves bits toward the LSB, so serial data enters at the MSB
      if (dir) begin
        q_d = {serial_in, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], serial_in};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_sequencer.sv
// Accepts a word plus shift command, shifts one bit per cycle, then holds the
// result until the consumer takes it.
//   state    | meaning
//   ST_IDLE  | ready for a command; accept cycle also loads the word
//   ST_SHIFT | one shift per cycle until the remaining count runs out
//   ST_RESP  | result presented, waiting for rsp_ready
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus,
  output logic              busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             rot_q, rot_d;
  logic             fill_q, fill_d;
  logic             carry_q, carry_d;

  logic             sr_en;
  logic             sr_load;
  logic             sr_sin;
  logic [WIDTH-1:0] word;
  logic             exit_bit;
  logic [CNT_W-1:0] eff_cnt;

  assign exit_bit = dir_q ? word[0] : word[WIDTH-1];
  assign eff_cnt  = (bus.cmd_count > MAX_CNT) ? MAX_CNT : bus.cmd_count;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    fill_d  = fill_q;
    carry_d = carry_q;
    sr_en   = 1'b0;
    sr_load = 1'b0;
    sr_sin  = rot_q ? exit_bit : fill_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          sr_load = 1'b1;
          dir_d   = bus.cmd_dir;
          rot_d   = bus.cmd_rotate;
          fill_d  = bus.cmd_fill;
          cnt_d   = eff_cnt;
          carry_d = 1'b0;
          state_d = (eff_cnt != '0) ? ST_SHIFT : ST_RESP;
        end
      end
      ST_SHIFT: begin
        sr_en   = 1'b1;
        carry_d = exit_bit;
        cnt_d   = cnt_q - ONE_CNT;
        // terminal count: the shift happening now is the last one
        if (cnt_q == ONE_CNT) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      fill_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      fill_q  <= fill_d;
      carry_q <= carry_d;
    end
  end

  // On a load cycle dir_q is stale, but load overrides shifting in the register.
  bidir_shift_reg #(
    .WIDTH (WIDTH)
  ) u_word (
    .clk       (clk),
    .rstn      (!rst),
    .en        (sr_en),
    .load      (sr_load),
    .dir       (dir_q),
    .serial_in (sr_sin),
    .d         (bus.cmd_data),
    .q         (word)
  );

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = word;
  assign bus.rsp_carry = carry_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (legal values are 2 or greater).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), meaning the width of the shift-count field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have port cmd_data  input  WIDTH  word to parallel-load.
REQ-008 SHALL have port cmd_dir  input  1  0 = shift left, 1 = shift right.
REQ-009 SHALL have port cmd_count  input  CNT_W  number of single-bit shifts.
REQ-010 SHALL have port cmd_rotate  input  1  1 = the exiting bit re-enters as serial input; 0 = cmd_fill enters.
REQ-011 SHALL have port cmd_fill  input  1  constant fill bit used when cmd_rotate=0.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port rsp_data  output  WIDTH  shifted word.
REQ-015 SHALL have port rsp_carry  output  1  last bit shifted out (0 if no shift occurred).
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement a four-state FSM: IDLE, SHIFT, RESP, plus LOAD, which is folded into the accept cycle (see REQ-018).
REQ-018 In IDLE: cmd_ready=1; a handshake (cmd_valid & cmd_ready) SHALL parallel-load cmd_data and latch dir, rotate, fill and the effective count in that same cycle.
REQ-019 The effective count SHALL be min(cmd_count, WIDTH); values above WIDTH are clamped.
REQ-020 After acceptance the next state SHALL be SHIFT if the effective count is nonzero, and RESP otherwise.
REQ-021 In SHIFT, exactly one shift SHALL occur per cycle in the latched direction, the remaining count SHALL decrement, and the exiting bit SHALL be captured into carry.
REQ-022 Serial input during a shift SHALL be the exiting bit when rotate=1, else the latched fill bit.
REQ-023 SHIFT SHALL transition to RESP in the cycle its last shift completes; no extra idle cycle is allowed.
REQ-024 Latency: for an accept edge at cycle 0, rsp_valid SHALL first be high at cycle N+1, where N is the effective count.
REQ-025 In RESP: rsp_valid=1, and rsp_data/rsp_carry SHALL hold stable until rsp_ready is high; on handshake the FSM SHALL go to IDLE.
REQ-026 cmd_ready SHALL be 0 in SHIFT and RESP; commands offered then are ignored, not queued.
REQ-027 carry SHALL clear to 0 at each command acceptance.
REQ-028 No combinational path SHALL exist from cmd_valid to cmd_ready, or from rsp_ready to rsp_valid.

Reset
REQ-029 While rst=1 at a clock edge: state becomes IDLE, the word register and carry clear to 0, and the counter clears.
REQ-030 Reset outputs: cmd_ready=1, rsp_valid=0, busy=0, rsp_data=0, rsp_carry=0.
REQ-031 Reset SHALL override any in-progress SHIFT or RESP; the aborted result is discarded.
REQ-032 Reset SHALL take priority over a simultaneous command handshake.

Structure
REQ-033 A shared package/header SHALL hold the FSM state encodings and the CNT_W derivation.
REQ-034 The word datapath SHALL be one instance of the team's bidir_shift_reg, with en/load/dir/serial_in driven by the FSM and its rstn tied to !rst.
REQ-035 The block SHALL contain no other sub-modules.

Verification (WIDTH=8)
REQ-036 Shift left with fill: data 0x96, dir 0, count 3, rotate 0, fill 0 -> rsp_data 0xB0, rsp_carry 0, rsp_valid at cycle 4.
REQ-037 Rotate right: data 0x01, dir 1, count 1, rotate 1 -> rsp_data 0x80, rsp_carry 1, rsp_valid at cycle 2.
REQ-038 Zero count and clamp (two commands): (a) data 0x5A, count 0 -> rsp_data 0x5A, carry 0, rsp_valid at cycle 1; (b) data 0xA5, dir 0, count 12, rotate 1 -> clamped to 8, rsp_data 0xA5, carry 1, rsp_valid at cycle 9.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_data/rsp_carry stable, cmd_ready 0, and a cmd_valid pulse during the stall is ignored.
REQ-040 Reset mid-SHIFT: assert rst at cycle 2 of a count-6 command -> next cycle IDLE, cmd_ready 1, rsp_valid 0, word register 0.
